// File: rtl/elink_tx_arbiter_if.sv
// Bus between the e-link TX arbiter, its packet sources and the 8b10b encoder.
// The arbiter takes the slave view; the source/encoder side takes the master view.
interface elink_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic                   enable;
  logic                   getDataTrig;
  logic [NUM_REQ-1:0]     req_valid;
  logic [10*NUM_REQ-1:0]  req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic [9:0]             edataIN;
  logic                   DATA_RDY;
  logic [NUM_REQ-1:0]     grant;
  logic                   busy;
  logic [7:0]             abort_cnt;
  logic [7:0]             drop_cnt;

  modport master (
    output enable, getDataTrig, req_valid, req_data,
    input  req_ready, edataIN, DATA_RDY, grant, busy, abort_cnt, drop_cnt
  );

  modport slave (
    input  enable, getDataTrig, req_valid, req_data,
    output req_ready, edataIN, DATA_RDY, grant, busy, abort_cnt, drop_cnt
  );
endinterface

// File: rtl/elink_tx_arbiter.sv
// Shares one 8b10b e-link encoder between NUM_REQ packet sources: atomic packets,
// round-robin grants, comma fill between words and abort of stalled packets.
module elink_tx_arbiter #(
  parameter int         NUM_REQ    = 4,
  parameter int         RDY_LEN    = 2,
  parameter int         MAX_STALL  = 8,
  parameter logic [7:0] ABORT_BYTE = 8'hFF
) (
  input  logic              bitCLKx4,
  input  logic              rst_n,
  elink_tx_arbiter_if.slave bus
);
  localparam int         IDXW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [9:0] COMMA      = 10'b11_0000_0000;
  localparam logic [9:0] ABORT_WORD = {2'b01, ABORT_BYTE};
  localparam logic [1:0] DLM_DATA   = 2'b00;
  localparam logic [1:0] DLM_EOP    = 2'b01;
  localparam logic [1:0] DLM_SOP    = 2'b10;

  typedef enum logic {IDLE, PKT} state_e;

  state_e            state_q, state_d;
  logic              trig_prev_q;
  logic [2:0]        rdy_cnt_q, rdy_cnt_d;
  logic [9:0]        data_q, data_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [IDXW-1:0]   owner_q, owner_d, rr_q, rr_d;
  logic [7:0]        stall_q, stall_d, abort_q, abort_d, drop_q, drop_d;

  logic              trig, fill;
  logic              sop_found, drop_found, own_valid;
  logic [IDXW-1:0]   sop_idx, drop_idx;
  logic [9:0]        sop_head, own_head;
  int                idx;

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Descending scans let the smallest RR offset (and lowest discard index) win.
  always_comb begin
    sop_found  = 1'b0;
    sop_idx    = '0;
    drop_found = 1'b0;
    drop_idx   = '0;
    idx        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[idx] && bus.req_data[10*idx+8 +: 2] == DLM_SOP) begin
        sop_found = 1'b1;
        sop_idx   = IDXW'(idx);
      end
      if (bus.req_valid[k] && bus.req_data[10*k+8 +: 2] != DLM_SOP) begin
        drop_found = 1'b1;
        drop_idx   = IDXW'(k);
      end
    end
  end

  assign sop_head  = bus.req_data[10*sop_idx +: 10];
  assign own_head  = bus.req_data[10*owner_q +: 10];
  assign own_valid = bus.req_valid[owner_q];
  assign trig      = bus.getDataTrig & ~trig_prev_q & (rdy_cnt_q == 3'd0);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    ready_d   = '0;
    owner_d   = owner_q;
    rr_d      = rr_q;
    stall_d   = stall_q;
    abort_d   = abort_q;
    drop_d    = drop_q;
    fill      = 1'b0;
    rdy_cnt_d = (rdy_cnt_q != 3'd0) ? rdy_cnt_q - 3'd1 : 3'd0;
    if (trig) begin
      rdy_cnt_d = 3'(RDY_LEN);
      data_d    = COMMA;
      if (state_q == IDLE) begin
        if (bus.enable && sop_found) begin
          data_d           = sop_head;
          ready_d[sop_idx] = 1'b1;
          owner_d          = sop_idx;
          stall_d          = 8'd0;
          state_d          = PKT;
        end
      end else if (own_valid) begin
        case (own_head[9:8])
          DLM_DATA: begin
            data_d           = own_head;
            ready_d[owner_q] = 1'b1;
            stall_d          = 8'd0;
          end
          DLM_EOP: begin
            data_d           = own_head;
            ready_d[owner_q] = 1'b1;
            rr_d             = next_idx(owner_q);
            state_d          = IDLE;
          end
          DLM_SOP: begin
            data_d  = ABORT_WORD;
            abort_d = sat_inc(abort_q);
            rr_d    = next_idx(owner_q);
            state_d = IDLE;
          end
          default: begin
            data_d           = own_head;
            ready_d[owner_q] = 1'b1;
            fill             = 1'b1;
          end
        endcase
      end else begin
        fill = 1'b1;
      end
      // Comma heads and missing words both count toward the stall limit.
      if (fill) begin
        stall_d = stall_q + 8'd1;
        if (stall_d == 8'(MAX_STALL)) begin
          data_d  = ABORT_WORD;
          abort_d = sat_inc(abort_q);
          rr_d    = next_idx(owner_q);
          state_d = IDLE;
        end
      end
    end else if (state_q == IDLE && bus.enable && drop_found && ready_q == '0) begin
      // A pop still in flight means the head has not advanced yet.
      ready_d[drop_idx] = 1'b1;
      drop_d            = sat_inc(drop_q);
    end
  end

  always_ff @(posedge bitCLKx4 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      trig_prev_q <= 1'b0;
      rdy_cnt_q   <= 3'd0;
      data_q      <= COMMA;
      ready_q     <= '0;
      owner_q     <= '0;
      rr_q        <= '0;
      stall_q     <= 8'd0;
      abort_q     <= 8'd0;
      drop_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= bus.getDataTrig;
      rdy_cnt_q   <= rdy_cnt_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      stall_q     <= stall_d;
      abort_q     <= abort_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.edataIN   = data_q;
  assign bus.DATA_RDY  = (rdy_cnt_q != 3'd0);
  assign bus.req_ready = ready_q;
  assign bus.busy      = (state_q == PKT);
  assign bus.grant     = (state_q == PKT) ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.abort_cnt = abort_q;
  assign bus.drop_cnt  = drop_q;
endmodule
